// File: rtl/uart_rx_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : uart_rx_fifo                                                     |
// | Brief   : 8N1 serial receiver with FWFT byte FIFO and sticky error flags.  |
// |           Define UART_RX_PARITY_EN for 8E1 frames with a parity_err flag.  |
// | Rev     : 1.0                                                              |
// +----------------------------------------------------------------------------+
module uart_rx_fifo #(
    parameter int DIV        = 434,
    parameter int FIFO_DEPTH = 8,
    parameter int LW         = $clog2(FIFO_DEPTH + 1)
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          ser_rx,
    output logic [7:0]    rd_data,
    output logic          rd_valid,
    input  logic          rd_ready,
    output logic [LW-1:0] level,
    output logic          overrun,
    output logic          frame_err,
`ifdef UART_RX_PARITY_EN
    output logic          parity_err,
`endif
    input  logic          err_clr
);

    localparam int c_CW = $clog2(DIV);
    localparam int c_PW = $clog2(FIFO_DEPTH);
    localparam logic [c_CW-1:0] c_CNT_HALF = c_CW'(DIV / 2 - 1);
    localparam logic [c_CW-1:0] c_CNT_LAST = c_CW'(DIV - 1);
    localparam logic [LW-1:0]   c_LVL_FULL = LW'(FIFO_DEPTH);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_STOP   = 3'd3,
        S_BREAK  = 3'd4,
        S_PARITY = 3'd5
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3,
        S_BREAK = 3'd4
    } state_t;
`endif

    logic            r_sync1, r_sync2;
    logic            w_rx;
    state_t          r_state, w_state_nxt;
    logic [c_CW-1:0] r_cnt, w_cnt_nxt;
    logic [2:0]      r_bit, w_bit_nxt;
    logic [7:0]      r_shift, w_shift_nxt;
    logic            w_push, w_frame_set;
    logic            w_cnt_last;
`ifdef UART_RX_PARITY_EN
    logic            r_par_bad, w_par_bad_nxt, w_parity_set;
    logic            r_parity_err;
`endif

    // Two-flop synchroniser; idles high so reset does not look like a start bit
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= ser_rx;
            r_sync2 <= r_sync1;
        end
    end
    assign w_rx = r_sync2;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
`ifdef UART_RX_PARITY_EN
            r_par_bad <= 1'b0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_bit   <= w_bit_nxt;
            r_shift <= w_shift_nxt;
`ifdef UART_RX_PARITY_EN
            r_par_bad <= w_par_bad_nxt;
`endif
        end
    end

    assign w_cnt_last = (r_cnt == c_CNT_LAST);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_bit_nxt   = r_bit;
        w_shift_nxt = r_shift;
        w_push      = 1'b0;
        w_frame_set = 1'b0;
`ifdef UART_RX_PARITY_EN
        w_par_bad_nxt = r_par_bad;
        w_parity_set  = 1'b0;
`endif
        case (r_state)
            S_IDLE: begin
                if (!w_rx) begin
                    w_state_nxt = S_START;
                    w_cnt_nxt   = '0;
`ifdef UART_RX_PARITY_EN
                    w_par_bad_nxt = 1'b0;
`endif
                end
            end
            S_START: begin
                // Mid-start recheck rejects short low glitches
                if (r_cnt == c_CNT_HALF) begin
                    w_cnt_nxt = '0;
                    if (!w_rx) begin
                        w_state_nxt = S_DATA;
                        w_bit_nxt   = '0;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            S_DATA: begin
                if (w_cnt_last) begin
                    w_shift_nxt = {w_rx, r_shift[7:1]};
                    w_cnt_nxt   = '0;
                    w_bit_nxt   = r_bit + 3'd1;
                    if (r_bit == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        w_state_nxt = S_PARITY;
`else
                        w_state_nxt = S_STOP;
`endif
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (w_cnt_last) begin
                    w_par_bad_nxt = ^{r_shift, w_rx};
                    w_parity_set  = ^{r_shift, w_rx};
                    w_cnt_nxt     = '0;
                    w_state_nxt   = S_STOP;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
`endif
            S_STOP: begin
                if (w_cnt_last) begin
                    w_cnt_nxt = '0;
                    if (w_rx) begin
`ifdef UART_RX_PARITY_EN
                        w_push = ~r_par_bad;
`else
                        w_push = 1'b1;
`endif
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_frame_set = 1'b1;
                        w_state_nxt = S_BREAK;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            S_BREAK: begin
                if (w_rx) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    logic [7:0]      r_mem [FIFO_DEPTH];
    logic [c_PW-1:0] r_wr_ptr, r_rd_ptr;
    logic [LW-1:0]   r_level;
    logic            r_overrun, r_frame_err;
    logic            w_pop, w_full, w_wr, w_ovr_set;

    assign rd_valid  = (r_level != '0);
    assign w_pop     = rd_valid & rd_ready;
    assign w_full    = (r_level == c_LVL_FULL);
    // A pop in the same cycle frees the slot, so a full FIFO still accepts
    assign w_wr      = w_push & (~w_full | w_pop);
    assign w_ovr_set = w_push & w_full & ~w_pop;

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= r_shift;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_level     <= '0;
            r_overrun   <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_wr, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
            r_overrun   <= w_ovr_set   | (r_overrun   & ~err_clr);
            r_frame_err <= w_frame_set | (r_frame_err & ~err_clr);
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_parity_err <= 1'b0;
        end else begin
            r_parity_err <= w_parity_set | (r_parity_err & ~err_clr);
        end
    end
    assign parity_err = r_parity_err;
`endif

    // Gate the head so an empty FIFO presents zero rather than stale RAM
    assign rd_data   = rd_valid ? r_mem[r_rd_ptr] : 8'h00;
    assign level     = r_level;
    assign overrun   = r_overrun;
    assign frame_err = r_frame_err;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_uart_rx_fifo                                                  |
// | Brief   : Scoreboard bench for uart_rx_fifo (default 8N1 build).           |
// | Rev     : 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_uart_rx_fifo;

    localparam int DIV    = 16;
    localparam int DEPTH  = 8;
    localparam int LW     = $clog2(DEPTH + 1);
    // Frame-relative cycle in which rd_ready must be high to coincide with the stop-sample push
    localparam int C_STOP = 9 * DIV + DIV / 2 + 2;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          ser_rx = 1'b1;
    logic          rd_ready = 1'b0;
    logic          err_clr = 1'b0;
    logic [7:0]    rd_data;
    logic          rd_valid;
    logic [LW-1:0] level;
    logic          overrun;
    logic          frame_err;

    int            n_cmp = 0;
    int            n_err = 0;
    logic [7:0]    exp_q[$];
    logic          exp_ovr = 1'b0;
    logic          pre_valid, post_valid;
    logic [7:0]    post_data;

    uart_rx_fifo #(.DIV(DIV), .FIFO_DEPTH(DEPTH)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .ser_rx    (ser_rx),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .rd_ready  (rd_ready),
        .level     (level),
        .overrun   (overrun),
        .frame_err (frame_err),
        .err_clr   (err_clr)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every handshake pops the oldest expected byte
    always @(negedge clk) begin
        if (resetn && rd_valid && rd_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL pop_unexpected: got 0x%0h expected no data", rd_data);
            end else begin
                check("pop_data", {24'd0, rd_data}, {24'd0, exp_q.pop_front()});
            end
        end
    end

    // Reference: a good frame lands if there is room, else it is lost and overrun is flagged
    task automatic model_frame(input logic [7:0] b, input bit pop_same_cycle);
        if (exp_q.size() < DEPTH || pop_same_cycle) exp_q.push_back(b);
        else exp_ovr = 1'b1;
    endtask

    // mode 0: rd_ready untouched, 1: rd_ready pulsed in the push cycle, 2: random rd_ready
    task automatic send(input logic [7:0] b, input logic stop, input int mode);
        logic [9:0] fr;
        fr = {stop, b, 1'b0};
        @(posedge clk); #1;
        for (int c = 0; c < 10 * DIV; c++) begin
            ser_rx = fr[c / DIV];
            if (mode == 1) rd_ready = (c == C_STOP);
            else if (mode == 2) rd_ready = 1'($urandom_range(0, 1));
            if (c == C_STOP) pre_valid = rd_valid;
            if (c == C_STOP + 1) begin
                post_valid = rd_valid;
                post_data  = rd_data;
            end
            @(posedge clk); #1;
        end
        ser_rx = 1'b1;
        if (mode != 0) rd_ready = 1'b0;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain();
        rd_ready = 1'b1;
        for (int i = 0; i < 4 * DEPTH && rd_valid; i++) begin
            @(posedge clk); #1;
        end
        rd_ready = 1'b0;
        check("drain_valid", {31'd0, rd_valid}, 32'd0);
        check("drain_leftover", exp_q.size(), 32'd0);
    endtask

    task automatic pulse_clr();
        err_clr = 1'b1;
        cycles(1);
        err_clr = 1'b0;
        exp_ovr = 1'b0;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] b;
        cycles(3);
        check("rst_valid", {31'd0, rd_valid}, 32'd0);
        check("rst_data", {24'd0, rd_data}, 32'd0);
        check("rst_level", {28'd0, level}, 32'd0);
        check("rst_flags", {30'd0, overrun, frame_err}, 32'd0);
        resetn = 1'b1;
        cycles(4);

        // Single byte, exact push latency
        model_frame(8'hA5, 1'b0);
        send(8'hA5, 1'b1, 0);
        check("a5_pre_valid", {31'd0, pre_valid}, 32'd0);
        check("a5_post_valid", {31'd0, post_valid}, 32'd1);
        check("a5_post_data", {24'd0, post_data}, 32'hA5);
        check("a5_level", {28'd0, level}, 32'd1);
        check("a5_flags", {30'd0, overrun, frame_err}, 32'd0);
        drain();

        // Short low glitch must not start a frame
        ser_rx = 1'b0;
        cycles(4);
        ser_rx = 1'b1;
        cycles(3 * DIV);
        check("glitch_level", {28'd0, level}, 32'd0);
        check("glitch_flags", {30'd0, overrun, frame_err}, 32'd0);

        // Overflow by one without pops
        for (int i = 0; i < DEPTH + 1; i++) begin
            model_frame(8'(i), 1'b0);
            send(8'(i), 1'b1, 0);
        end
        check("ovf_level", {28'd0, level}, exp_q.size());
        check("ovf_overrun", {31'd0, overrun}, {31'd0, exp_ovr});
        check("ovf_head", {24'd0, rd_data}, {24'd0, exp_q[0]});
        drain();
        pulse_clr();
        check("ovf_cleared", {31'd0, overrun}, 32'd0);

        // Bad stop bit followed by a long break gives one frame error
        send(8'h55, 1'b0, 0);
        ser_rx = 1'b0;
        cycles(2);
        check("brk_ferr", {31'd0, frame_err}, 32'd1);
        check("brk_level", {28'd0, level}, 32'd0);
        pulse_clr();
        check("brk_clr", {31'd0, frame_err}, 32'd0);
        cycles(40 * DIV);
        check("brk_once", {31'd0, frame_err}, 32'd0);
        ser_rx = 1'b1;
        cycles(2 * DIV);
        model_frame(8'h3C, 1'b0);
        send(8'h3C, 1'b1, 0);
        check("brk_3c_data", {24'd0, rd_data}, 32'h3C);
        check("brk_3c_ferr", {31'd0, frame_err}, 32'd0);
        drain();

        // Full FIFO with a pop coinciding with the push
        for (int i = 0; i < DEPTH; i++) begin
            b = 8'($urandom);
            model_frame(b, 1'b0);
            send(b, 1'b1, 0);
        end
        check("full_level", {28'd0, level}, DEPTH);
        b = 8'($urandom);
        model_frame(b, 1'b1);
        send(b, 1'b1, 1);
        check("pp_level", {28'd0, level}, DEPTH);
        check("pp_overrun", {31'd0, overrun}, 32'd0);
        drain();

        // Random bytes with random consumer back-pressure
        for (int i = 0; i < 6; i++) begin
            b = 8'($urandom);
            model_frame(b, 1'b0);
            send(b, 1'b1, 2);
        end
        drain();
        check("rand_overrun", {31'd0, overrun}, 32'd0);

        // Reset mid-frame discards both stored and in-flight data
        model_frame(8'h77, 1'b0);
        send(8'h77, 1'b1, 0);
        check("pre_rst_level", {28'd0, level}, 32'd1);
        ser_rx = 1'b0;
        cycles(DIV);
        ser_rx = 1'b1;
        cycles(3 * DIV);
        resetn = 1'b0;
        exp_q.delete();
        cycles(1);
        check("mid_rst_valid", {31'd0, rd_valid}, 32'd0);
        check("mid_rst_data", {24'd0, rd_data}, 32'd0);
        check("mid_rst_level", {28'd0, level}, 32'd0);
        check("mid_rst_flags", {30'd0, overrun, frame_err}, 32'd0);
        cycles(2);
        resetn = 1'b1;
        cycles(12 * DIV);
        check("post_rst_level", {28'd0, level}, 32'd0);
        model_frame(8'h12, 1'b0);
        send(8'h12, 1'b1, 0);
        check("post_rst_count", {28'd0, level}, 32'd1);
        check("post_rst_data", {24'd0, rd_data}, 32'h12);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
